// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC readout stage: state encoding,
// tap-count defaults and the per-sample code/bubble functions.
package tdc_pkg;

    localparam int NTAPS_DEF = 8;
    localparam int MAX_TAPS  = 64;
    localparam int CODE_W    = $clog2(NTAPS_DEF + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tdc_state_e;

    // Number of set taps; callers zero-extend narrower tap vectors.
    function automatic logic [6:0] popcount(input logic [MAX_TAPS-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < MAX_TAPS; i++) begin
            c = c + {6'd0, v[i]};
        end
        return c;
    endfunction

    // A valid thermometer never has a set tap above a clear one.
    function automatic logic is_thermo(input logic [MAX_TAPS-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 1; i < MAX_TAPS; i++) begin
            if (v[i] && !v[i-1]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/tdc_sync.sv
// Multi-flop synchronizer for the asynchronous TDC taps; only the last
// stage is visible to the rest of the block.
module tdc_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] q;
            if (gi == 0) begin : g_in
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q <= '0;
                    end else begin
                        q <= d_i;
                    end
                end
            end else begin : g_in
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q <= '0;
                    end else begin
                        q <= g_stage[gi-1].q;
                    end
                end
            end
        end
    endgenerate

    assign q_o = g_stage[STAGES-1].q;

endmodule

// File: rtl/tdc_readout.sv
// Readout stage for the vernier TDC: settles, samples the synchronized
// thermometer, accumulates a burst of codes and hands the sum downstream.
module tdc_readout
    import tdc_pkg::*;
#(
    parameter int NTAPS       = NTAPS_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int AVG_LOG2    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NTAPS-1:0]                       term_in,
    input  logic                                   trig,
    input  logic                                   clear,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [$clog2(NTAPS+1)+AVG_LOG2-1:0]    out_sum,
    output logic [AVG_LOG2:0]                      out_bubbles,
    output logic                                   overrun
);

    localparam int CW        = $clog2(NTAPS + 1);
    localparam int SUM_W     = CW + AVG_LOG2;
    localparam int BUB_W     = AVG_LOG2 + 1;
    localparam int N_W       = AVG_LOG2 + 1;
    localparam int CNT_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [N_W-1:0] BURST_LEN = N_W'(1) << AVG_LOG2;

    logic [NTAPS-1:0] sync_taps;
    logic [CW-1:0]    code;
    logic             bubble;

    tdc_state_e       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
    logic [BUB_W-1:0] acc_bub_q, acc_bub_d;
    logic [N_W-1:0]   n_q,       n_d;
    logic             ovr_q,     ovr_d;

    tdc_sync #(
        .WIDTH  (NTAPS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (term_in),
        .q_o   (sync_taps)
    );

    assign code   = CW'(popcount(MAX_TAPS'(sync_taps)));
    assign bubble = ~is_thermo(MAX_TAPS'(sync_taps));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_sum_q <= '0;
            acc_bub_q <= '0;
            n_q       <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_sum_q <= acc_sum_d;
            acc_bub_q <= acc_bub_d;
            n_q       <= n_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_sum_d = acc_sum_q;
        acc_bub_d = acc_bub_q;
        n_d       = n_q;
        ovr_d     = ovr_q;

        // A trigger can only start a measurement from IDLE; anything else is lost.
        if (trig && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SAMPLE: begin
                acc_sum_d = acc_sum_q + SUM_W'(code);
                acc_bub_d = acc_bub_q + BUB_W'(bubble);
                n_d       = n_q + N_W'(1);
                state_d   = (n_d == BURST_LEN) ? DONE : IDLE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d   = IDLE;
                    acc_sum_d = '0;
                    acc_bub_d = '0;
                    n_d       = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // clear wins over both a trigger and a completing handshake.
        if (clear) begin
            state_d   = IDLE;
            cnt_d     = '0;
            acc_sum_d = '0;
            acc_bub_d = '0;
            n_d       = '0;
            ovr_d     = 1'b0;
        end
    end

    assign out_valid   = (state_q == DONE);
    assign out_sum     = acc_sum_q;
    assign out_bubbles = acc_bub_q;
    assign overrun     = ovr_q;

endmodule

// File: doc/tdc_readout.md
# tdc_readout

Synchronous readout stage directly downstream of the vernier-buffer TDC core. It samples the eight asynchronous thermometer taps after each fired measurement and converts each sample to a binary code with bubble detection. It accumulates a burst of 2^AVG_LOG2 samples and presents the sum through a valid/ready handshake to the digital readout path.

## Interface
- NTAPS, 8, number of thermometer taps from the TDC core
- SYNC_STAGES, 2, synchronizer depth per tap, minimum 2
- SETTLE_CYC, 4, cycles waited after a trigger before sampling, minimum 1
- AVG_LOG2, 4, log2 of samples per burst, range 0..8
- clk  input  1  single clock for the whole block
- rst_n  input  1  asynchronous, active-low reset, applies to all flops
- term_in  input  NTAPS  raw taps from the TDC core, asynchronous to clk
- trig  input  1  synchronous one-cycle pulse: a start/stop pair has just been fired
- clear  input  1  synchronous; aborts the burst, zeroes accumulators, clears overrun
- out_valid  output  1  burst result available
- out_ready  input  1  consumer accepts result
- out_sum  output  $clog2(NTAPS+1)+AVG_LOG2  sum of codes in burst
- out_bubbles  output  AVG_LOG2+1  number of samples in burst with bubble errors
- overrun  output  1  sticky: a trig was dropped

## Operation
- Synchronizer: each term_in bit passes through SYNC_STAGES flops, reset value 0; only the last stage is used.
- Code per sample = popcount of synchronized taps, 0..NTAPS.
- Bubble when the sample is not a valid thermometer: some tap i set while tap i-1 is clear, tap 0 counting as the base.
  - Example: 0x0B → code 3, bubble.
  - Example: 0x07 → code 3, no bubble.
- FSM states are IDLE, SETTLE, SAMPLE, DONE. Reset state is IDLE.
- IDLE: trig=1 → SETTLE; settle counter loads SETTLE_CYC-1.
- SETTLE: counter decrements each cycle; when counter is 0 → SAMPLE.
- SAMPLE, one cycle:
  - acc_sum += code.
  - acc_bub += bubble.
  - n += 1.
  - When n reaches 2^AVG_LOG2 → DONE; otherwise → IDLE.
- DONE:
  - out_valid=1; out_sum and out_bubbles are driven from the accumulators and held stable.
  - On out_valid && out_ready → IDLE, and acc_sum, acc_bub and n are zeroed in the same cycle.
- trig seen in any state other than IDLE is dropped and sets overrun. overrun clears only on clear or reset.
- clear, from any state:
  - Next state IDLE.
  - acc_sum, acc_bub, n and overrun zeroed; out_valid drops.
  - clear has priority over trig and over the handshake in the same cycle.
- Arithmetic: the accumulators are sized so they cannot wrap: max sum NTAPS·2^AVG_LOG2, max bubble count 2^AVG_LOG2. n is AVG_LOG2+1 bits wide.
- When AVG_LOG2=0, every SAMPLE goes to DONE.

## Timing
- Reset values:
  - out_valid=0, out_sum=0, out_bubbles=0, overrun=0.
  - Synchronizer flops 0; state IDLE.
- The trig that completes a burst is sampled at edge T:
  - SAMPLE occupies the cycle after edge T+SETTLE_CYC.
  - out_valid rises after edge T+SETTLE_CYC+1.
- Sampled tap values reflect term_in at least SYNC_STAGES cycles before the sample edge. Callers choose SETTLE_CYC ≥ SYNC_STAGES so that the core settles.
- The handshake completes on the edge where both out_valid and out_ready are 1. The earliest next trig is accepted in the following cycle.
- out_ready is ignored while out_valid=0.
- Asserting rst_n low mid-burst forces every output to its reset value immediately, without waiting for a clock edge.

## Structure
- Package tdc_pkg holds:
  - NTAPS default.
  - tdc_state_e enum: IDLE, SETTLE, SAMPLE, DONE.
  - Code-width constant $clog2(NTAPS+1).
  - Popcount and thermometer-validity functions.
- Sub-module tdc_sync is an NTAPS-wide, SYNC_STAGES-deep synchronizer with async active-low reset.
- The FSM, counters and accumulators live in tdc_readout.

## Test plan
All scenarios use AVG_LOG2=2, SETTLE_CYC=4, SYNC_STAGES=2.
- Reset: hold rst_n=0 with term_in=0xFF and trig toggling → out_valid=0, out_sum=0, out_bubbles=0, overrun=0. After release, the first trig is accepted normally.
- Steady code: term_in=0x0F held, 4 trigs spaced 8 cycles apart → out_sum=16 and out_bubbles=0. out_valid rises 5 edges after the 4th trig edge.
- Mixed and bubbles: samples 0x01, 0x03, 0x0B, 0xFF → out_sum=1+2+3+8=14, out_bubbles=1.
- Backpressure:
  - Burst completes with out_ready=0; trig is pulsed during DONE → out_sum holds, overrun=1.
  - Raise out_ready → handshake completes; the next 4×0x07 burst gives out_sum=12 with overrun still 1.
- Clear mid-burst: 2 samples of 0xFF, then clear → accumulators zero and overrun=0. The next 4×0x03 burst gives out_sum=8.
- Trig during SETTLE: a second trig arrives 2 cycles after the first → dropped, overrun=1. n increments only once.
